nibble_serial_alu_ctrl: RTL and testbench

//  Multi-cycle sequencer that performs WIDTH-bit add/subtract by reusing one 4-bit carry-lookahead slice.
//  It processes one nibble per cycle, LSB first, and registers the carry between nibbles.

---
 rtl/nibble_serial_alu_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_alu_ctrl_cla4.sv | 29 ++
 rtl/nibble_serial_alu_ctrl.sv | 136 +++++++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared encodings for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/nibble_serial_alu_ctrl_cla4.sv
// 4-bit carry-lookahead slice; purely combinational, with group generate/propagate.
module nibble_cla4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout,
  output logic       g_grp,
  output logic       p_grp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a4 & b4;
    p = a4 ^ b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
    cout = g_grp | (p_grp & cin);
    s4 = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// WIDTH-bit add/subtract sequencer reusing one 4-bit CLA slice, one nibble per cycle, LSB first.
//   state   | meaning
//   IDLE    | waiting for start, ready=1
//   RUN     | one nibble per cycle through the slice, busy=1
//   DONE    | result/flags valid, done pulses; start here chains the next op
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SLICES = WIDTH / 4;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_e           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-5:0] acc;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] b_eff;
  logic             c_init;
  logic [3:0]       s4;
  logic             cout;
  logic [WIDTH-1:0] wide;

  always_comb begin
    b_eff  = b;
    c_init = 1'b0;
    case (op_e'(op))
      OP_ADD: begin b_eff = b;  c_init = 1'b0;     end
      OP_SUB: begin b_eff = ~b; c_init = 1'b1;     end
      OP_ADC: begin b_eff = b;  c_init = carry_in; end
      OP_SBC: begin b_eff = ~b; c_init = carry_in; end
      default: begin b_eff = b; c_init = 1'b0;     end
    endcase
  end

  nibble_cla4 u_cla (
    .a4   (a_r[3:0]),
    .b4   (b_r[3:0]),
    .cin  (carry_r),
    .s4   (s4),
    .cout (cout),
    .g_grp(),
    .p_grp()
  );

  // Newest nibble enters at the top; after SLICES cycles the word is in LSB-first order.
  assign wide = {s4, acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b_eff;
            carry_r <= c_init;
            cnt     <= '0;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b_eff[WIDTH-1];
            state   <= ST_RUN;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> 4;
          b_r     <= b_r >> 4;
          acc     <= wide[WIDTH-1:4];
          carry_r <= cout;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(SLICES - 1)) begin
            state  <= ST_DONE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= wide;
            flag_n <= s4[3];
            flag_z <= (wide == '0);
            flag_c <= cout;
            flag_v <= (a_msb == b_msb) && (s4[3] != a_msb);
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl with hand-computed expected values.
module tb_nibble_serial_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        carry_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic        flag_n, flag_z, flag_c, flag_v;

  int errors = 0;
  int checks = 0;
  int lat;
  int pulses;

  nibble_serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .carry_in(carry_in),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until done is seen, bounded; 99 marks a timeout.
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic ci,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] exp_res, input logic [3:0] exp_nzcv);
    int n;
    @(negedge clk);
    op = o; carry_in = ci; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(n);
    check({tag, "_lat"}, n, 32'd8);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_nzcv"}, {28'b0, flag_n, flag_z, flag_c, flag_v}, {28'b0, exp_nzcv});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    do_op("add_1_1",   2'b00, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000);
    do_op("add_wrap",  2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    do_op("add_ovf",   2'b00, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    do_op("sub_neg",   2'b01, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1000);
    do_op("sbc_c0",    2'b11, 1'b0, 32'h0000_0010, 32'h0000_0001, 32'h0000_000E, 4'b0010);
    do_op("adc_c1",    2'b10, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 4'b0000);
    do_op("add_ign_ci", 2'b00, 1'b1, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000);
    do_op("sub_zero",  2'b01, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
    do_op("sub_vovf",  2'b01, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011);

    // start and operand changes during RUN must not disturb the op in flight
    @(negedge clk);
    op = 2'b00; a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
    @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        check("mid_res", result, 32'h2345_6789);
      end
    end
    check("mid_pulses", pulses, 32'd1);
    check("mid_idle_ready", {31'b0, ready}, 32'd1);

    // back-to-back: start held through DONE
    @(negedge clk);
    op = 2'b00; a = 32'h0000_0001; b = 32'h0000_0002; start = 1'b1;
    wait_done(lat);
    check("b2b_lat1", lat, 32'd9);
    check("b2b_res1", result, 32'h0000_0003);
    a = 32'h0000_0010; b = 32'h0000_0020;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap", {31'b0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_lat2", lat, 32'd8);
    check("b2b_res2", result, 32'h0000_0030);

    // reset in the middle of RUN aborts the op
    @(negedge clk);
    op = 2'b00; a = 32'h0000_0055; b = 32'h0000_0022; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_flags", {28'b0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);
    do_op("post_rst_add", 2'b00, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
